// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory-stage controller.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT
  } mem_state_e;

  // Request payload presented to the data memory.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              rd;
    logic              wr;
  } mem_req_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory access; tc_c flags the last
// permitted cycle. TIMEOUT of 0 disables the terminal count.
module mem_wait_timer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic             TC_EN  = (TIMEOUT != 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc_c = TC_EN & en & (cnt == TC_VAL);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: request/done handshake with a stalling data memory,
// pipeline freeze and one write-back result per instruction.
// Optional MEM_ALIGN_CHECK_EN: odd load/store addresses abort without a request.
module mem_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [WORD_W-1:0] ex_alu_out,
  input  logic [WORD_W-1:0] ex_wdata,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall_pipe,
  output logic              wb_valid,
  output logic [WORD_W-1:0] wb_data,
  output logic              mem_err
);

  mem_state_e        state, state_d;
  mem_req_t          req_q, req_d;
  logic              is_load_q, is_load_d;
  logic              wb_valid_d, mem_err_d;
  logic [WORD_W-1:0] wb_data_d;
  logic              access, misalign;
  logic              tmr_clr, tmr_en, tmo_c;

  assign access = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ex_alu_out[0];
`else
  assign misalign = 1'b0;
`endif

  assign tmr_en = (state == S_REQ) | (state == S_WAIT);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc_c  (tmo_c)
  );

  // Next-state, next-output and pipeline-stall decode.
  always_comb begin
    state_d    = state;
    req_d      = req_q;
    is_load_d  = is_load_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data;
    mem_err_d  = 1'b0;
    stall_pipe = 1'b0;
    tmr_clr    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (access && misalign) begin
          mem_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_data_d  = '0;
        end else if (access) begin
          // A simultaneous read and write is resolved as a read.
          stall_pipe  = 1'b1;
          tmr_clr     = 1'b1;
          req_d.addr  = ex_alu_out;
          req_d.wdata = ex_wdata;
          req_d.rd    = ex_mem_read;
          req_d.wr    = ~ex_mem_read;
          is_load_d   = ex_mem_read;
          state_d     = S_REQ;
        end else if (ex_valid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ex_alu_out;
        end
      end

      S_REQ: begin
        if (tmo_c) begin
          req_d.rd   = 1'b0;
          req_d.wr   = 1'b0;
          mem_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_data_d  = '0;
          state_d    = S_IDLE;
        end else begin
          stall_pipe = 1'b1;
          if (!mem_stall) begin
            req_d.rd = 1'b0;
            req_d.wr = 1'b0;
            state_d  = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Completion takes priority over an expiring timer.
        if (mem_done) begin
          wb_valid_d = 1'b1;
          wb_data_d  = is_load_q ? mem_rdata : req_q.addr;
          state_d    = S_IDLE;
        end else if (tmo_c) begin
          mem_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_data_d  = '0;
          state_d    = S_IDLE;
        end else begin
          stall_pipe = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_q     <= '0;
      is_load_q <= 1'b0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_d;
      req_q     <= req_d;
      is_load_q <= is_load_d;
      wb_valid  <= wb_valid_d;
      wb_data   <= wb_data_d;
      mem_err   <= mem_err_d;
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_rd    = req_q.rd;
  assign mem_wr    = req_q.wr;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: two instances (TIMEOUT 32 and 4) on shared stimulus,
// each compared every cycle against a transaction-level model, plus literal checks.
module tb_mem_stage_ctrl;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [15:0] ex_alu_out, ex_wdata;
  logic        mem_stall, mem_done;
  logic [15:0] mem_rdata;

  logic [15:0] d_addr, d_wdata, d_wbd, t_addr, t_wdata, t_wbd;
  logic        d_rd, d_wr, d_stall, d_wbv, d_err;
  logic        t_rd, t_wr, t_stall, t_wbv, t_err;

  int n_tests;
  int n_fail;
  bit chk_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(32), .CNT_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_out(ex_alu_out), .ex_wdata(ex_wdata),
    .mem_addr(d_addr), .mem_wdata(d_wdata), .mem_rd(d_rd), .mem_wr(d_wr),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_pipe(d_stall), .wb_valid(d_wbv), .wb_data(d_wbd), .mem_err(d_err)
  );

  mem_stage_ctrl #(.TIMEOUT(4), .CNT_W(6)) u_to (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_out(ex_alu_out), .ex_wdata(ex_wdata),
    .mem_addr(t_addr), .mem_wdata(t_wdata), .mem_rd(t_rd), .mem_wr(t_wr),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_pipe(t_stall), .wb_valid(t_wbv), .wb_data(t_wbd), .mem_err(t_err)
  );

  // Outstanding-access model: age = cycles already spent since the access was taken.
  typedef struct packed {
    logic        busy;
    logic        accepted;
    logic        is_load;
    logic [31:0] age;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] wb_data;
    logic        rd;
    logic        wr;
    logic        wb_valid;
    logic        err;
  } mdl_t;

  mdl_t m32, m4;

  function automatic mdl_t mdl_next(input mdl_t m, input int unsigned tmo);
    mdl_t n;
    bit   acc;
    bit   expired;
    n          = m;
    n.wb_valid = 1'b0;
    n.err      = 1'b0;
    acc        = ex_valid && (ex_mem_read || ex_mem_write);
    expired    = (tmo != 0) && (m.age + 32'd1 == tmo);
    if (!rst_n) begin
      n = '0;
    end else if (!m.busy) begin
      if (acc && ALIGN_CHK && ex_alu_out[0]) begin
        n.err = 1'b1; n.wb_valid = 1'b1; n.wb_data = 16'h0;
      end else if (acc) begin
        n.busy = 1'b1; n.accepted = 1'b0; n.age = 32'd0;
        n.is_load = ex_mem_read; n.addr = ex_alu_out; n.wdata = ex_wdata;
        n.rd = ex_mem_read; n.wr = !ex_mem_read;
      end else if (ex_valid) begin
        n.wb_valid = 1'b1; n.wb_data = ex_alu_out;
      end
    end else if (m.accepted && mem_done) begin
      n.busy = 1'b0; n.wb_valid = 1'b1;
      n.wb_data = m.is_load ? mem_rdata : m.addr;
    end else if (expired) begin
      n.busy = 1'b0; n.rd = 1'b0; n.wr = 1'b0;
      n.err = 1'b1; n.wb_valid = 1'b1; n.wb_data = 16'h0;
    end else begin
      n.age = m.age + 32'd1;
      if (!m.accepted && !mem_stall) begin
        n.accepted = 1'b1; n.rd = 1'b0; n.wr = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic bit mdl_stall(input mdl_t m, input int unsigned tmo);
    bit acc;
    acc = ex_valid && (ex_mem_read || ex_mem_write);
    if (!m.busy) return acc && !(ALIGN_CHK && ex_alu_out[0]);
    if (m.accepted && mem_done) return 1'b0;
    return !((tmo != 0) && (m.age + 32'd1 == tmo));
  endfunction

  always @(posedge clk) begin
    m32 <= mdl_next(m32, 32);
    m4  <= mdl_next(m4, 4);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input int unsigned tmo,
                     input logic [15:0] addr, input logic [15:0] wdata,
                     input logic rd, input logic wr, input logic stall,
                     input logic wbv, input logic [15:0] wbd, input logic err);
    check({tag, ".mem_rd"}, 16'(rd), 16'(m.rd));
    check({tag, ".mem_wr"}, 16'(wr), 16'(m.wr));
    check({tag, ".stall_pipe"}, 16'(stall), 16'(mdl_stall(m, tmo)));
    check({tag, ".wb_valid"}, 16'(wbv), 16'(m.wb_valid));
    check({tag, ".mem_err"}, 16'(err), 16'(m.err));
    if (m.rd || m.wr) begin
      check({tag, ".mem_addr"}, addr, m.addr);
      check({tag, ".mem_wdata"}, wdata, m.wdata);
    end
    if (m.wb_valid) check({tag, ".wb_data"}, wbd, m.wb_data);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("dut32", m32, 32, d_addr, d_wdata, d_rd, d_wr, d_stall, d_wbv, d_wbd, d_err);
      cmp("dut4", m4, 4, t_addr, t_wdata, t_rd, t_wr, t_stall, t_wbv, t_wbd, t_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_alu_out = 16'h0; ex_wdata = 16'h0;
    mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    rst_n   = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk_en = 1'b1;
    rst_n  = 1'b1;
    settle();
    check("rst.mem_addr", d_addr, 16'h0);
    check("rst.mem_wdata", d_wdata, 16'h0);
    check("rst.mem_rd", 16'(d_rd), 16'h0);
    check("rst.wb_data", d_wbd, 16'h0);
    check("rst.stall_pipe", 16'(d_stall), 16'h0);

    // Pass-through ALU results, single and back-to-back.
    ex_valid = 1'b1; ex_alu_out = 16'h1234;
    settle();
    check("alu.stall", 16'(d_stall), 16'h0);
    tick();
    ex_alu_out = 16'hA001;
    settle();
    check("alu.wb_valid", 16'(d_wbv), 16'h1);
    check("alu.wb_data", d_wbd, 16'h1234);
    tick();
    ex_alu_out = 16'hA002;
    tick();
    ex_valid = 1'b0;
    settle();
    check("b2b.wb_data", d_wbd, 16'hA002);
    tick();
    settle();
    check("alu.wb_idle", 16'(d_wbv), 16'h0);

    // Load: no stall, done after one WAIT cycle.
    do_reset();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_out = 16'h0040;
    settle();
    check("ld.stall_c0", 16'(d_stall), 16'h1);
    check("ld.rd_c0", 16'(d_rd), 16'h0);
    tick();
    settle();
    check("ld.rd_c1", 16'(d_rd), 16'h1);
    check("ld.addr_c1", d_addr, 16'h0040);
    check("ld.stall_c1", 16'(d_stall), 16'h1);
    tick();
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    settle();
    check("ld.stall_c2", 16'(d_stall), 16'h0);
    check("ld.rd_c2", 16'(d_rd), 16'h0);
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0; mem_done = 1'b0;
    settle();
    check("ld.wb_valid", 16'(d_wbv), 16'h1);
    check("ld.wb_data", d_wbd, 16'hBEEF);
    tick();
    settle();
    check("ld.wb_once", 16'(d_wbv), 16'h0);

    // Store held in REQ by mem_stall for three cycles.
    do_reset();
    ex_valid = 1'b1; ex_mem_write = 1'b1; ex_alu_out = 16'h0100; ex_wdata = 16'hCAFE;
    mem_stall = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_stall = 1'b0;
      settle();
      check("st.wr_req", 16'(d_wr), 16'h1);
      check("st.addr_req", d_addr, 16'h0100);
      check("st.wdata_req", d_wdata, 16'hCAFE);
      tick();
    end
    settle();
    check("st.wr_wait", 16'(d_wr), 16'h0);
    tick();
    mem_done = 1'b1;
    tick();
    ex_valid = 1'b0; ex_mem_write = 1'b0; mem_done = 1'b0;
    settle();
    check("st.wb_valid", 16'(d_wbv), 16'h1);
    check("st.wb_data", d_wbd, 16'h0100);
    tick();
    settle();
    check("st.wb_once", 16'(d_wbv), 16'h0);
    check("st.no_reissue", 16'(d_wr), 16'h0);

    // Timeout on the TIMEOUT=4 instance; the 32 instance completes later.
    do_reset();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_out = 16'h0200;
    for (int i = 0; i < 4; i++) tick();
    settle();
    check("to.stall_c4", 16'(t_stall), 16'h0);
    check("to.err_c4", 16'(t_err), 16'h0);
    check("to.long_stall_c4", 16'(d_stall), 16'h1);
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    mem_done = 1'b1; mem_rdata = 16'h1357;
    settle();
    check("to.err_c5", 16'(t_err), 16'h1);
    check("to.wb_valid_c5", 16'(t_wbv), 16'h1);
    check("to.wb_data_c5", t_wbd, 16'h0);
    check("to.stall_c5", 16'(t_stall), 16'h0);
    check("to.rd_c5", 16'(t_rd), 16'h0);
    tick();
    mem_done = 1'b0;
    settle();
    check("to.late_done_ignored", 16'(t_wbv), 16'h0);
    check("to.long_wb_data", d_wbd, 16'h1357);
    tick();

    // Completion and timer expiry in the same cycle: completion wins.
    do_reset();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_out = 16'h0210;
    for (int i = 0; i < 4; i++) tick();
    mem_done = 1'b1; mem_rdata = 16'h2468;
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0; mem_done = 1'b0;
    settle();
    check("race.wb_valid", 16'(t_wbv), 16'h1);
    check("race.wb_data", t_wbd, 16'h2468);
    check("race.err", 16'(t_err), 16'h0);
    tick();

    // Reset while WAIT is outstanding; a stale done afterwards is ignored.
    do_reset();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_out = 16'h0300;
    tick();
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_done = 1'b1; mem_rdata = 16'h5555;
    settle();
    check("mid_rst.addr", d_addr, 16'h0);
    check("mid_rst.rd", 16'(d_rd), 16'h0);
    check("mid_rst.stall", 16'(d_stall), 16'h0);
    check("mid_rst.wb_data", d_wbd, 16'h0);
    tick();
    mem_done = 1'b0;
    settle();
    check("mid_rst.wb_valid", 16'(d_wbv), 16'h0);
    check("mid_rst.err", 16'(d_err), 16'h0);
    tick();

    // Read and write together behave as a read.
    do_reset();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b1;
    ex_alu_out = 16'h0400; ex_wdata = 16'h1111;
    tick();
    settle();
    check("rw.rd", 16'(d_rd), 16'h1);
    check("rw.wr", 16'(d_wr), 16'h0);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h7777;
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; mem_done = 1'b0;
    settle();
    check("rw.wb_data", d_wbd, 16'h7777);
    tick();

    // Odd address.
    do_reset();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_out = 16'h0003;
`ifdef MEM_ALIGN_CHECK_EN
    settle();
    check("odd.stall", 16'(d_stall), 16'h0);
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    settle();
    check("odd.rd", 16'(d_rd), 16'h0);
    check("odd.err", 16'(d_err), 16'h1);
    check("odd.wb_valid", 16'(d_wbv), 16'h1);
    check("odd.wb_data", d_wbd, 16'h0);
    tick();
    settle();
    check("odd.rd_after", 16'(d_rd), 16'h0);
`else
    settle();
    check("odd.stall", 16'(d_stall), 16'h1);
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    settle();
    check("odd.rd", 16'(d_rd), 16'h1);
    check("odd.addr", d_addr, 16'h0003);
    check("odd.err", 16'(d_err), 16'h0);
    tick();
    mem_done = 1'b1; mem_rdata = 16'h0ABC;
    tick();
    mem_done = 1'b0;
    settle();
    check("odd.wb_data", d_wbd, 16'h0ABC);
`endif
    tick();
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller at the consuming end of the execute stage's result interface.
- Takes the ALU result (used as address or pass-through data) and the store data from EX/MEM, and runs a multi-cycle request/done handshake with the stalling data memory.
- Freezes upstream stages while an access is outstanding, then presents one write-back result per instruction.

Parameters:
- TIMEOUT, 32, max cycles spent in REQ+WAIT before abort; 0 disables timeout.
- CNT_W, 6, width of wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_alu_out  in  16  ALU result; address for loads/stores, else write-back value
- ex_wdata  in  16  store data (second register operand)
- mem_addr  out  16  data memory address
- mem_wdata  out  16  data memory write data
- mem_rd  out  1  read request
- mem_wr  out  1  write request
- mem_stall  in  1  memory busy; request not accepted this cycle
- mem_done  in  1  access complete; mem_rdata valid for loads
- mem_rdata  in  16  read data
- stall_pipe  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- wb_valid  out  1  one-cycle pulse, write-back result valid
- wb_data  out  16  load data or pass-through ALU result
- mem_err  out  1  one-cycle pulse, access aborted

Behaviour:
- Reset (rst_n low at posedge): state IDLE, counter 0. All registered outputs 0: mem_addr, mem_wdata, mem_rd, mem_wr, wb_valid, wb_data, mem_err. stall_pipe=0.
- access = ex_valid & (ex_mem_read | ex_mem_write).
- ex_mem_read and ex_mem_write both high is illegal; treat as read.
- State IDLE:
  - access: latch ex_alu_out/ex_wdata/type into mem_addr/mem_wdata/mem_rd or mem_wr; go to REQ.
  - ex_valid & !access: next cycle wb_valid=1, wb_data=ex_alu_out; no stall.
  - !ex_valid: wb_valid=0.
  - mem_done is ignored in IDLE (e.g. a stale response after reset).
- State REQ:
  - mem_rd/mem_wr held high, address and data held stable.
  - mem_stall=0 at posedge: request accepted; clear mem_rd/mem_wr; go to WAIT.
  - mem_stall=1: stay in REQ.
  - mem_done ignored.
- State WAIT:
  - mem_done=1: go to IDLE; next cycle wb_valid=1.
  - wb_data = mem_rdata for a load; for a store, wb_data = mem_addr and wb_valid=1 (the write-back stage ignores it).
- stall_pipe, combinational: (state==REQ) | (state==WAIT & !mem_done) | (state==IDLE & access).
  - It drops in the mem_done cycle, so EX/MEM advances on that edge; the held instruction is never re-accepted.
- Minimum load latency: accept edge, then REQ 1 cycle, WAIT 1 cycle, wb_valid on the 4th cycle.
- Timeout counter:
  - Counts cycles in REQ/WAIT; cleared on entering REQ.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without mem_done: clear mem_rd/mem_wr, mem_err=1 for one cycle, wb_valid=1 with wb_data=0, go to IDLE.
  - stall_pipe drops that same cycle.
- mem_done and timeout in the same cycle: mem_done wins, no error.
- Reset mid-access: outstanding request abandoned; no wb_valid or mem_err is produced for it.
- Ordering: at most one access outstanding; wb_valid order equals program order.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined: in IDLE, an access with ex_alu_out[0]=1 issues no request. It pulses mem_err and wb_valid (wb_data=0) next cycle, with stall_pipe=0.
- Undefined: odd addresses are passed to memory unchanged.

Decomposition:
- Shared package (cpu_pkg) holds:
  - state encoding localparams ST_IDLE=2'd0, ST_REQ=2'd1, ST_WAIT=2'd2;
  - WORD_W=16.
- One natural sub-module: mem_wait_timer (counter with clear, enable, and terminal-count output, parameterised by TIMEOUT/CNT_W).

Test Plan:
- Non-memory op: ex_valid=1, ex_alu_out=16'h1234 -> stall_pipe=0, wb_valid next cycle, wb_data=16'h1234.
- Load, mem_stall=0, mem_done after 1 WAIT cycle with mem_rdata=16'hBEEF:
  - mem_rd high exactly 1 cycle, mem_addr=ex_alu_out;
  - stall_pipe high 2 cycles;
  - wb_data=16'hBEEF.
- Store with mem_stall high 3 cycles then done:
  - mem_wr and mem_addr/mem_wdata stable for all 4 REQ cycles;
  - single wb_valid;
  - no re-issue.
- TIMEOUT=4, mem_done never asserted -> mem_err pulse in the 5th cycle after accept, wb_data=0, state IDLE, stall_pipe=0.
- rst_n low during WAIT, then mem_done arrives in IDLE -> no wb_valid, all outputs 0.
- MEM_ALIGN_CHECK_EN, load at 16'h0003 -> mem_rd never asserted, mem_err=1, stall_pipe=0.
